fetch_prefetch_buffer: RTL
==========================

Name: fetch_prefetch_buffer

Overview:
- Instruction-fetch front end that sits directly upstream of decode, i.e. upstream of the register file, main control and immediate generator.
- Generates sequential fetch PCs into instruction memory and buffers the returned words in a small FIFO of {pc, instr} entries.
- Presents those entries to decode over a valid/ready handshake.
- Accepts a branch/jump redirect that flushes the buffer and restarts fetch at the target.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  byte address of fetch (always equals the internal fetch_pc).
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rdata  input  32  instruction word; valid in the same cycle as imem_req && imem_gnt.
- redirect_valid  input  1  branch/jump taken; flush and restart.
- redirect_pc  input  32  redirect target byte address.
- id_valid  output  1  head entry available to decode.
- id_ready  input  1  decode consumes the head entry this cycle.
- id_instr  output  32  head instruction; 0 when empty.
- id_pc  output  32  PC of head instruction; 0 when empty.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, rst=1):
  - fetch_pc=RESET_PC; read/write pointers=0; count=0; state=BOOT.
  - Outputs: imem_req=0, id_valid=0, id_instr=0, id_pc=0, fifo_count=0, imem_addr=RESET_PC.
  - Reset asserted mid-operation discards all entries immediately.
- FSM states: BOOT, RUN, FLUSH.
  - BOOT -> RUN on the first clock after rst deasserts. No request is issued in BOOT.
  - RUN -> FLUSH when redirect_valid=1.
  - FLUSH -> RUN unconditionally after 1 cycle, unless redirect_valid=1 again (then stay in FLUSH and reload fetch_pc).
  - redirect_valid in BOOT is honoured: fetch_pc<=redirect_pc, next state FLUSH.
- Request rule: imem_req = (state==RUN) && !redirect_valid && (count < DEPTH). There is no fetch-through-full: at count==DEPTH no request is made even if a pop occurs the same cycle.
- Push: imem_req && imem_gnt. Write {fetch_pc, imem_rdata} at wr_ptr; wr_ptr+1 mod DEPTH; fetch_pc<=fetch_pc+4, 32-bit wrap (32'hFFFF_FFFC -> 0).
- imem_gnt=0 with imem_req=1: hold fetch_pc; retry next cycle.
- Pop: id_valid && id_ready. rd_ptr+1 mod DEPTH.
- id_valid = (count != 0) && (state != FLUSH).
- id_instr and id_pc are driven from the head entry; both are 0 when count==0.
- Occupancy: push and pop in the same cycle leave count unchanged. Otherwise count changes by +1 or -1.
- Redirect (highest priority):
  - Same cycle: any memory response is discarded and no pop is counted (id_valid is still driven as above; decode must ignore it).
  - Next edge: count=0, pointers=0, fetch_pc=redirect_pc.
  - First request at redirect_pc is issued 2 cycles after the redirect edge (after FLUSH).
- redirect_pc[1:0] is ignored; fetch_pc is forced word-aligned ({redirect_pc[31:2],2'b00}).
- Latency without bypass: an instruction pushed at edge N is visible on id_valid from cycle N+1.
- id_ready while id_valid=0 has no effect.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined: when count==0, state==RUN, and the push and pop conditions coincide, imem_rdata and imem_addr pass combinationally to id_instr and id_pc with id_valid=1.
  - If id_ready=1 the word is consumed that cycle and not written; count stays 0.
  - If id_ready=0 it is pushed normally.
- Not defined: the minimum latency is 1 cycle, as above, and id_* are always registered-storage outputs.

Test Plan:
- Reset release, imem_gnt=1, id_ready=0, imem_rdata=32'h0000_0013 -> imem_addr sequence 0,4,8,12. Requests stop after 4 pushes; fifo_count=4; imem_req=0.
- Full FIFO, then id_ready=1 for 1 cycle -> id_pc=0, id_instr=32'h13 consumed; fifo_count=3; imem_req reasserts next cycle at addr 16.
- Steady state id_ready=1, imem_gnt=1 -> a push and a pop every cycle; fifo_count constant; id_pc increments by 4 per cycle.
- Redirect while count=3, redirect_pc=32'h0000_002C -> next cycle fifo_count=0, id_valid=0. After FLUSH, imem_addr=32'h2C; first id_pc=32'h2C.
- Back-to-back redirects to 32'h30 then 32'h40, and redirect_pc=32'h43 -> only 32'h40 is fetched; the 32'h43 case yields imem_addr=32'h40.
- rst asserted mid-stream with count=2 -> outputs reach reset values asynchronously; after release the first request is at RESET_PC.
- Stall: imem_gnt=0 for 3 cycles -> imem_addr is held constant and no push occurs.

Source files
------------

// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch front end: sequential PC generation, {pc, instr} prefetch FIFO, decode handshake.
// Optional macro PREFETCH_BYPASS_EN forwards a fetched word straight to decode when the FIFO is empty.
module fetch_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic                     o_imem_req,
  output logic [31:0]              o_imem_addr,
  input  logic                     i_imem_gnt,
  input  logic [31:0]              i_imem_rdata,
  input  logic                     i_redirect_valid,
  input  logic [31:0]              i_redirect_pc,
  output logic                     o_id_valid,
  input  logic                     i_id_ready,
  output logic [31:0]              o_id_instr,
  output logic [31:0]              o_id_pc,
  output logic [$clog2(DEPTH):0]   o_fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t        r_state;
  logic [31:0]   r_fetchPc;
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pcMem    [DEPTH];
  logic [31:0]   r_instrMem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_req;
  logic w_push;
  logic w_bufValid;
  logic w_bypass;
  logic w_pushBuf;
  logic w_popBuf;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_req      = (r_state == RUN) && !i_redirect_valid && !w_full;
  assign w_push     = w_req && i_imem_gnt;
  assign w_bufValid = !w_empty && (r_state != FLUSH);

`ifdef PREFETCH_BYPASS_EN
  // w_push already implies RUN and no redirect
  assign w_bypass = w_empty && w_push;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word taken by decode this cycle never enters storage
  assign w_pushBuf = w_push && !(w_bypass && i_id_ready);
  assign w_popBuf  = w_bufValid && i_id_ready && !i_redirect_valid;

  assign o_imem_req   = w_req;
  assign o_imem_addr  = r_fetchPc;
  assign o_fifo_count = r_count;
  assign o_id_valid   = w_bufValid || w_bypass;

  always_comb begin
    o_id_instr = 32'h0;
    o_id_pc    = 32'h0;
    if (w_bypass) begin
      o_id_instr = i_imem_rdata;
      o_id_pc    = r_fetchPc;
    end else if (!w_empty) begin
      o_id_instr = r_instrMem[r_rdPtr];
      o_id_pc    = r_pcMem[r_rdPtr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_pushBuf && !i_rst) begin
      r_pcMem[r_wrPtr]    <= r_fetchPc;
      r_instrMem[r_wrPtr] <= i_imem_rdata;
    end
  end

  // Redirect outranks every other update, including the BOOT -> RUN step
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= BOOT;
      r_fetchPc <= RESET_PC;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
    end else if (i_redirect_valid) begin
      r_state   <= FLUSH;
      r_fetchPc <= {i_redirect_pc[31:2], 2'b00};
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        BOOT:    r_state <= RUN;
        FLUSH:   r_state <= RUN;
        default: r_state <= RUN;
      endcase
      if (w_push) begin
        r_fetchPc <= r_fetchPc + 32'd4;
      end
      if (w_pushBuf) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_popBuf) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_pushBuf, w_popBuf})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
